// File: rtl/fx2_wb_burst_writer_pkg.sv
// Shared definitions for the FX2 -> Wishbone burst writer and its buffer.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
package fx2_wb_burst_writer_pkg;

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_FIFO_DW = 16;
    localparam int DEF_WB_DW   = 32;

    // Index width for n entries; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fx2_wb_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read data, full/empty flags and occupancy count.
// Latency: a pushed entry is visible at pop_dat_o the cycle after the push edge.
// Backpressure: push is accepted when not full or when a pop happens on the same edge.
module fx2_wb_sync_fifo
    import fx2_wb_burst_writer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_dat_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          pop_dat_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);
    localparam int AW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Storage array; contents are don't-care while empty so it carries no reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/fx2_wb_burst_writer.sv
// Drains an FX2 slave FIFO, packs words into WB beats and writes one programmed-length pipelined Wishbone burst.
// Latency: busy 1 cycle after start; first FX2 read on the 2nd RUN cycle; a buffered beat strobes the cycle after its push.
// Backpressure: FX2 reads pause while the beat buffer is full; stall_o holds the request; at most MAX_OUT requests await ack.
module fx2_wb_burst_writer
    import fx2_wb_burst_writer_pkg::*;
#(
    parameter int         FIFO_DW   = DEF_FIFO_DW,
    parameter int         WB_DW     = DEF_WB_DW,
    parameter int         ADDR_W    = 32,
    parameter int         LEN_W     = 16,
    parameter int         BUF_DEPTH = 8,
    parameter int         MAX_OUT   = 4,
    parameter logic [1:0] EP_ADDR   = 2'b00
) (
    input  logic                CLKOUT,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    input  logic                FLAGA,
    input  logic [FIFO_DW-1:0]  FDATA,
    output logic                SLRD,
    output logic                SLOE,
    output logic                SLWR,
    output logic                IFCLK,
    output logic [1:0]          FIFOADR,
    output logic                cyc_i,
    output logic                stb_i,
    output logic                we_i,
    output logic [WB_DW/8-1:0]  sel_i,
    output logic [ADDR_W-1:0]   addr_i,
    output logic [WB_DW-1:0]    data_i,
    input  logic                sdram_ack,
    input  logic                stall_o
);
    localparam int PACK   = WB_DW / FIFO_DW;
    localparam int PIDX_W = idx_w(PACK);
    localparam int WCNT_W = LEN_W + PIDX_W;
    localparam int OUT_W  = cnt_w(MAX_OUT);

    state_e                       state_q, state_d;
    logic [LEN_W-1:0]             len_q, issued_q, issued_d, acks_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [WCNT_W-1:0]            words_q, words_total;
    logic [OUT_W-1:0]             out_q, out_d;
    logic [PIDX_W-1:0]            pidx_q;
    logic [WB_DW-1:0]             pack_q, beat, f_head;
    logic                         cyc_q, cyc_d, armed_q;
    logic                         in_wb, stb, accept, ack_ok, rd_fire, push;
    logic                         f_full, f_empty;
    logic [cnt_w(BUF_DEPTH)-1:0]  f_count;
    logic                         unused_fcount;

    // Handshake terms for both the FX2 side and the Wishbone side, plus next counter values
    always_comb begin
        in_wb       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        words_total = WCNT_W'(len_q) * WCNT_W'(PACK);
        stb         = in_wb && !f_empty && (issued_q < len_q) && (out_q < OUT_W'(MAX_OUT));
        accept      = stb && !stall_o;
        ack_ok      = sdram_ack && (out_q != '0);
        // A pop on this edge frees a slot, so a full buffer does not block the read
        rd_fire     = (state_q == ST_RUN) && armed_q && FLAGA && (!f_full || accept)
                      && (words_q < words_total);
        push        = rd_fire && (pidx_q == PIDX_W'(PACK - 1));
        beat        = pack_q;
        beat[int'(pidx_q) * FIFO_DW +: FIFO_DW] = FDATA;
        issued_d    = issued_q + LEN_W'(accept);
        out_d       = out_q;
        if (accept && !ack_ok) begin
            out_d = out_q + OUT_W'(1);
        end else if (!accept && ack_ok) begin
            out_d = out_q - OUT_W'(1);
        end
        cyc_d       = (cyc_q || stb) && !((out_d == '0) && (issued_d == len_q));
    end

    // State register
    always_ff @(posedge CLKOUT) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and FX2 strobes / status outputs
    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        SLOE    = 1'b1;
        SLRD    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                SLOE = 1'b0;
                SLRD = !rd_fire;
                if (rd_fire && ((words_q + WCNT_W'(1)) == words_total)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (acks_q == len_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, word packing, address and transaction counters
    always_ff @(posedge CLKOUT) begin
        if (rst) begin
            len_q    <= '0;
            addr_q   <= '0;
            words_q  <= '0;
            issued_q <= '0;
            acks_q   <= '0;
            out_q    <= '0;
            pidx_q   <= '0;
            pack_q   <= '0;
            cyc_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else if ((state_q == ST_IDLE) && start) begin
            len_q    <= len;
            addr_q   <= base_addr;
            words_q  <= '0;
            issued_q <= '0;
            acks_q   <= '0;
            out_q    <= '0;
            pidx_q   <= '0;
            pack_q   <= '0;
            cyc_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            // SLOE is low for one full cycle before the first read strobe
            armed_q <= (state_q == ST_RUN);
            if (rd_fire) begin
                pack_q[int'(pidx_q) * FIFO_DW +: FIFO_DW] <= FDATA;
                pidx_q  <= push ? '0 : pidx_q + PIDX_W'(1);
                words_q <= words_q + WCNT_W'(1);
            end
            if (accept) addr_q <= addr_q + ADDR_W'(1);
            if (ack_ok) acks_q <= acks_q + LEN_W'(1);
            issued_q <= issued_d;
            out_q    <= out_d;
            cyc_q    <= cyc_d;
        end
    end

    fx2_wb_sync_fifo #(
        .WIDTH (WB_DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i      (CLKOUT),
        .rst_i      (rst),
        .push_i     (push),
        .push_dat_i (beat),
        .pop_i      (accept),
        .pop_dat_o  (f_head),
        .full_o     (f_full),
        .empty_o    (f_empty),
        .count_o    (f_count)
    );

    assign unused_fcount = ^f_count;

    assign SLWR    = 1'b1;
    assign IFCLK   = CLKOUT;
    assign FIFOADR = EP_ADDR;
    assign stb_i   = stb;
    assign cyc_i   = in_wb && (cyc_q || stb);
    assign we_i    = cyc_i;
    assign sel_i   = '1;
    assign addr_i  = addr_q;
    assign data_i  = f_empty ? '0 : f_head;

endmodule
